data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter: ADDR_W, default 12, byte-address bits decoded; depth = 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter: CLEAR_ON_RESET, default 1, 1 = zero whole array after reset, 0 = array contents untouched by reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  request present this cycle.
REQ-006 Port: req_ready  output  1  block accepts a request this cycle.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port: rsp_valid  output  1  response pulse for one accepted request.
REQ-012 Port: rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 Port: rsp_err  output  1  misaligned or illegal request; qualified by rsp_valid.
REQ-014 Port: busy  output  1  clear sequence in progress.

Function
REQ-015 States: CLEAR, READY; handshake accept = req_valid && req_ready; req_ready = 1 only in READY and not in reset.
REQ-016 CLEAR: clear counter writes 0 to word[cnt] each cycle, cnt 0 -> depth-1; transition to READY on the cycle after word depth-1 is written; clear duration exactly depth cycles.
REQ-017 Word index = req_addr[ADDR_W-1:2]; bits [31:ADDR_W] ignored (address wraps modulo 2^ADDR_W).
REQ-018 Alignment: H/HU need addr[0]=0, W needs addr[1:0]=00; violation sets rsp_err, no array write.
REQ-019 Illegal codes: load funct3 011/110/111, store funct3 other than 000/001/010 -> rsp_err, no array write.
REQ-020 Store: byte lanes selected by addr[1:0] and size; only those lanes updated at the accepting edge; other lanes of the word preserved.
REQ-021 Load: lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-022 Latency: rsp_valid high exactly 1 cycle after acceptance, for exactly 1 cycle per accepted request; fully pipelined, one request per cycle, no back-pressure on response.
REQ-023 Load accepted the cycle after a store to the same word returns the stored data (no stale read).
REQ-024 Without acceptance, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.

Reset
REQ-025 While reset = 1: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, cnt 0; busy 1 if CLEAR_ON_RESET else 0.
REQ-026 Reset release: CLEAR_ON_RESET=1 enters CLEAR; CLEAR_ON_RESET=0 enters READY immediately.
REQ-027 Reset asserted mid-CLEAR or mid-request: in-flight response discarded, counter restarts at 0 on release.
REQ-028 Request presented during reset or CLEAR: not accepted, no write, no response.

Verification
REQ-029 ADDR_W=12, reset 1 cycle then release -> busy high exactly 1024 cycles, req_ready rises next cycle, load W at 0xFFC returns 0x00000000.
REQ-030 SW 0x8000_80FF at 0x010, then LB 0x010 -> 0xFFFF_FFFF; LBU 0x010 -> 0x0000_00FF; LH 0x012 -> 0xFFFF_8000; LHU 0x012 -> 0x0000_8000.
REQ-031 SW 0x1122_3344 at 0x020, SB 0xAA at 0x021, back-to-back LW 0x020 -> 0x1122_AA44, rsp_valid on consecutive cycles.
REQ-032 SH at 0x031 and LW at 0x022 -> rsp_err=1, rsp_rdata=0, subsequent LW 0x030 unchanged.
REQ-033 SW 0xDEAD_BEEF at 0x1004 (ADDR_W=12) -> LW 0x004 returns 0xDEAD_BEEF (wrap).
REQ-034 Reset pulse at cnt=500 of CLEAR with req_valid held high -> no rsp_valid, busy held, clear restarts and lasts full 1024 cycles.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: RV32I data memory with byte/half/word loads and stores.
// After reset, an optional sequence writes zero to every word, one word per
// cycle. Requests are then accepted one per cycle and answered exactly one
// cycle later.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   req_valid  - request present this cycle
//   req_ready  - request accepted this cycle (READY state, not in reset)
//   req_we     - 1 = store, 0 = load
//   req_funct3 - size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr   - byte address; only [ADDR_W-1:0] is decoded
//   req_wdata  - store data, right-aligned
//   rsp_valid  - one-cycle response pulse per accepted request
//   rsp_rdata  - extended load data; 0 for stores and errors
//   rsp_err    - misaligned or illegal request
//   busy       - clear sequence in progress
module data_mem #(
    parameter int unsigned ADDR_W         = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic               w_clr_we;

    logic [31:0]        r_mem [DEPTH];

    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [31:0]        r_rsp_rdata;

    logic               w_accept;
    logic               w_legal;
    logic               w_misaligned;
    logic               w_err;
    logic               w_wr;
    logic [IDX_W-1:0]   w_idx;
    logic [1:0]         w_off;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_rd_shift;
    logic [31:0]        w_load_data;
    logic               w_unused;

    // Upper address bits are ignored: the address wraps modulo 2^ADDR_W.
    assign w_unused = ^req_addr[31:ADDR_W];

    // State and clear-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: walk the counter across every word, then open for requests.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we  = 1'b1;
                w_cnt_nxt = r_cnt + IDX_W'(1);
                if (r_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    // Reset overrides the state so that nothing is accepted while it is held.
    assign req_ready = (r_state == ST_READY) && !reset;
    assign busy      = reset ? CLEAR_ON_RESET : (r_state == ST_CLEAR);
    assign w_accept  = req_valid && req_ready;

    // Request decode: legality, alignment, byte enables, lane-replicated data.
    always_comb begin
        w_idx        = req_addr[ADDR_W-1:2];
        w_off        = req_addr[1:0];

        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_we;
            default:                w_legal = 1'b0;
        endcase

        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = w_off[0];
            2'b10:   w_misaligned = |w_off;
            default: w_misaligned = 1'b0;
        endcase

        w_err = !w_legal || w_misaligned;
        w_wr  = w_accept && req_we && !w_err;

        w_be        = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_off;
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << w_off;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b1111;
            end
            default: begin
            end
        endcase
    end

    // Load path: move the addressed lane to bit 0, then extend.
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_rd_shift = w_rd_word >> {w_off, 3'b000};
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            3'b001:  w_load_data = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b010:  w_load_data = w_rd_word;
            3'b100:  w_load_data = {24'h000000, w_rd_shift[7:0]};
            3'b101:  w_load_data = {16'h0000, w_rd_shift[15:0]};
            default: w_load_data = 32'h0000_0000;
        endcase
    end

    // Storage array: clear writes and store writes never coincide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_we) begin
                r_mem[r_cnt] <= 32'h0000_0000;
            end else if (w_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response register, one cycle behind acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_err;
            r_rsp_rdata <= (w_accept && !w_err && !req_we) ? w_load_data : 32'h0000_0000;
        end
    end

    // A response in flight when reset rises is dropped immediately.
    assign rsp_valid = r_rsp_valid && !reset;
    assign rsp_err   = r_rsp_err && !reset;
    assign rsp_rdata = reset ? 32'h0000_0000 : r_rsp_rdata;

endmodule

// File: tb/tb_data_mem.sv
// Testbench for data_mem (ADDR_W=12, CLEAR_ON_RESET=1).
// A byte-level memory model predicts every cycle's outputs; directed sequences
// add literal checks of specific load results.
module tb_data_mem;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned NBYTES = 4096;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    data_mem #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_mem [NBYTES];
    int          since_rel = 0;
    bit          chk_en = 0;
    logic        m_v = 0;
    logic        m_e = 0;
    logic [31:0] m_d = 0;

    always @(posedge clk) begin
        int unsigned a;
        int unsigned size;
        bit          legal;
        logic [31:0] val;
        chk_en = 1;
        m_v = 0;
        m_e = 0;
        m_d = 0;
        if (reset) begin
            since_rel = 0;
            for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
        end else begin
            if (req_valid && since_rel >= DEPTH) begin
                m_v   = 1;
                a     = req_addr % NBYTES;
                size  = (req_funct3[1:0] == 2'd0) ? 1 : (req_funct3[1:0] == 2'd1) ? 2 : 4;
                legal = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                               : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                if (!legal || (a % size) != 0) begin
                    m_e = 1;
                end else if (req_we) begin
                    for (int i = 0; i < size; i++) m_mem[a + i] = req_wdata[8*i +: 8];
                end else begin
                    val = 0;
                    for (int i = 0; i < size; i++) val = val | (32'(m_mem[a + i]) << (8 * i));
                    if (!req_funct3[2] && size < 4 && val[8*size-1])
                        val = val | (32'hFFFF_FFFF << (8 * size));
                    m_d = val;
                end
            end
            if (since_rel < DEPTH) since_rel++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", req_ready, (!reset && since_rel >= DEPTH) ? 1 : 0);
            chk("cyc_busy",  busy,      (reset || since_rel < DEPTH) ? 1 : 0);
            chk("cyc_rsp_valid", rsp_valid, reset ? 0 : m_v);
            chk("cyc_rsp_err",   rsp_err,   reset ? 0 : m_e);
            chk("cyc_rsp_rdata", rsp_rdata, reset ? 0 : m_d);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input string name, input logic [31:0] d, input logic e);
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, rsp_valid, 1);
        chk({name, "_rdata"}, rsp_rdata, d);
        chk({name, "_err"},   rsp_err,   e);
    endtask

    // Counts busy cycles after reset release; returns at the first idle negedge.
    task automatic wait_clear(input string name);
        int n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk({name, "_len"},   n, DEPTH);
        chk({name, "_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy",  busy, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err",   rsp_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear("clear0");

        req(0, 3'b010, 32'h0000_0FFC, 0);
        rsp("lw_ffc", 32'h0000_0000, 0);

        // Sign / zero extension
        req(1, 3'b010, 32'h0000_0010, 32'h8000_80FF);
        rsp("sw_010", 32'h0, 0);
        req(0, 3'b000, 32'h0000_0010, 0);
        rsp("lb_010", 32'hFFFF_FFFF, 0);
        req(0, 3'b100, 32'h0000_0010, 0);
        rsp("lbu_010", 32'h0000_00FF, 0);
        req(0, 3'b001, 32'h0000_0012, 0);
        rsp("lh_012", 32'hFFFF_8000, 0);
        req(0, 3'b101, 32'h0000_0012, 0);
        rsp("lhu_012", 32'h0000_8000, 0);

        // Back-to-back store, byte store, load of the same word
        req(1, 3'b010, 32'h0000_0020, 32'h1122_3344);
        req(1, 3'b000, 32'h0000_0021, 32'h0000_00AA);
        req(0, 3'b010, 32'h0000_0020, 0);
        rsp("b2b_lw_020", 32'h1122_AA44, 0);

        // Misaligned requests leave memory untouched
        req(1, 3'b010, 32'h0000_0030, 32'h5566_7788);
        rsp("sw_030", 32'h0, 0);
        req(1, 3'b001, 32'h0000_0031, 32'h0000_FFFF);
        rsp("sh_031", 32'h0, 1);
        req(0, 3'b010, 32'h0000_0022, 0);
        rsp("lw_022", 32'h0, 1);
        req(0, 3'b010, 32'h0000_0030, 0);
        rsp("lw_030", 32'h5566_7788, 0);

        // Illegal funct3 codes
        req(1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        req(1, 3'b100, 32'h0000_0040, 32'h0000_0000);
        rsp("sbu_illegal", 32'h0, 1);
        req(0, 3'b011, 32'h0000_0040, 0);
        rsp("ld_illegal", 32'h0, 1);
        req(0, 3'b010, 32'h0000_0040, 0);
        rsp("lw_040", 32'hCAFE_F00D, 0);

        // Address wrap
        req(1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
        req(0, 3'b010, 32'h0000_0004, 0);
        rsp("wrap_lw_004", 32'hDEAD_BEEF, 0);

        // Mixed-size stream checked by the model only
        for (int i = 0; i < 12; i++) begin
            req(1, 3'(i % 3), 32'h0000_0200 + 32'(i), 32'h8172_63F4 + 32'(i * 32'h0101_0101));
        end
        for (int i = 0; i < 12; i++) begin
            logic [2:0] codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            req(0, codes[i % 5], 32'h0000_0200 + 32'(i), 0);
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Reset during an in-flight load drops the response
        req(0, 3'b010, 32'h0000_0010, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("inflight_drop", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear("clear1");

        // Reset pulse part-way through clear with a request held
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0030;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear("clear2");
        req_valid = 1'b0;

        req(0, 3'b010, 32'h0000_0030, 0);
        rsp("lw_030_cleared", 32'h0000_0000, 0);
        req(0, 3'b010, 32'h0000_0004, 0);
        rsp("lw_004_cleared", 32'h0000_0000, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
